enemy_car: RTL and testbench

ENEMY_CAR -- requirements
Module: enemy_car

---
 rtl/road_pkg.sv | 17 +
 rtl/enemy_car.sv | 156 +++++++++++++++
 tb/tb_enemy_car.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/road_pkg.sv
// road_pkg: screen geometry, enemy-car sprite defaults and the enemy-car
// state encoding shared by the road-scene objects.
package road_pkg;

   localparam int DEF_SCREEN_W     = 640;
   localparam int DEF_SCREEN_H     = 480;
   localparam int DEF_CAR_W        = 16;
   localparam int DEF_CAR_H        = 32;
   localparam int DEF_BLINK_FRAMES = 60;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MOVING  = 2'd1,
      ST_CRASHED = 2'd2
   } car_state_e;

endpackage

// File: rtl/enemy_car.sv
// enemy_car: one falling enemy car sprite.
//   A spawn pulse in IDLE launches the car at the top of the screen. Each
//   frame (refresh_tick) it falls by 'speed' pixels until it leaves the
//   visible area. A crash pulse freezes it and makes it blink yellow for
//   BLINK_FRAMES frames before it disappears.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   pixel_x, pixel_y      raster position being drawn
//   refresh_tick          one pulse per frame
//   spawn, spawn_x, speed launch request, left edge, pixels per frame
//   crash                 collision pulse
//   car_on, car_r/g/b     registered pixel hit and colour (1 clk latency)
//   active                registered "car exists" flag
module enemy_car
   import road_pkg::*;
#(
   parameter int CAR_W        = DEF_CAR_W,
   parameter int CAR_H        = DEF_CAR_H,
   parameter int SCREEN_W     = DEF_SCREEN_W,
   parameter int SCREEN_H     = DEF_SCREEN_H,
   parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       refresh_tick,
   input  logic       spawn,
   input  logic [9:0] spawn_x,
   input  logic [2:0] speed,
   input  logic       crash,
   output logic       car_on,
   output logic       car_r,
   output logic       car_g,
   output logic       car_b,
   output logic       active
);

   // blink_cnt needs at least bit 2 for the blink phase.
   localparam int BLINK_W = ($clog2(BLINK_FRAMES + 1) < 3) ? 3 : $clog2(BLINK_FRAMES + 1);
   localparam logic [9:0]  X_MAX   = 10'(SCREEN_W - CAR_W);
   localparam logic [10:0] Y_LIMIT = 11'(SCREEN_H);

   car_state_e         state_q, state_d;
   logic [9:0]         x_left_q, x_left_d;
   logic [10:0]        y_top_q, y_top_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               car_on_q, car_on_d;
   logic               car_r_q, car_r_d;
   logic               car_g_q, car_g_d;
   logic               car_b_q, car_b_d;
   logic               active_q, active_d;

   logic [10:0] y_next;
   logic [10:0] px, py, xl, dy;
   logic        hit;

   // Next-state / position logic.
   always_comb begin
      state_d     = state_q;
      x_left_d    = x_left_q;
      y_top_d     = y_top_q;
      blink_cnt_d = blink_cnt_q;
      y_next      = y_top_q + {8'd0, speed};
      case (state_q)
         ST_IDLE: begin
            if (spawn) begin
               x_left_d = (spawn_x > X_MAX) ? X_MAX : spawn_x;
               y_top_d  = 11'd0;
               state_d  = ST_MOVING;
            end
         end
         ST_MOVING: begin
            // crash has priority over the frame advance
            if (crash) begin
               state_d     = ST_CRASHED;
               blink_cnt_d = BLINK_W'(BLINK_FRAMES);
            end else if (refresh_tick) begin
               if (y_next >= Y_LIMIT) state_d = ST_IDLE;
               else                   y_top_d = y_next;
            end
         end
         ST_CRASHED: begin
            if (refresh_tick) begin
               if (blink_cnt_q == BLINK_W'(1)) begin
                  state_d     = ST_IDLE;
                  blink_cnt_d = '0;
               end else begin
                  blink_cnt_d = blink_cnt_q - BLINK_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Hit test and colour, evaluated against the current (pre-edge) car.
   always_comb begin
      px       = {1'b0, pixel_x};
      py       = {1'b0, pixel_y};
      xl       = {1'b0, x_left_q};
      dy       = py - y_top_q;
      hit      = (px >= xl) && (px < xl + 11'(CAR_W)) &&
                 (py >= y_top_q) && (py < y_top_q + 11'(CAR_H));
      car_on_d = 1'b0;
      car_r_d  = 1'b0;
      car_g_d  = 1'b0;
      car_b_d  = 1'b0;
      if (hit && state_q == ST_MOVING) begin
         car_on_d = 1'b1;
         car_r_d  = 1'b1;
         // rows 8..11 form the white windscreen stripe
         if (dy >= 11'd8 && dy <= 11'd11) begin
            car_g_d = 1'b1;
            car_b_d = 1'b1;
         end
      end else if (hit && state_q == ST_CRASHED && blink_cnt_q[2]) begin
         car_on_d = 1'b1;
         car_r_d  = 1'b1;
         car_g_d  = 1'b1;
      end
      // active reflects the state being entered so it rises with the spawn edge
      active_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         x_left_q    <= '0;
         y_top_q     <= '0;
         blink_cnt_q <= '0;
         car_on_q    <= 1'b0;
         car_r_q     <= 1'b0;
         car_g_q     <= 1'b0;
         car_b_q     <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_left_q    <= x_left_d;
         y_top_q     <= y_top_d;
         blink_cnt_q <= blink_cnt_d;
         car_on_q    <= car_on_d;
         car_r_q     <= car_r_d;
         car_g_q     <= car_g_d;
         car_b_q     <= car_b_d;
         active_q    <= active_d;
      end
   end

   assign car_on = car_on_q;
   assign car_r  = car_r_q;
   assign car_g  = car_g_q;
   assign car_b  = car_b_q;
   assign active = active_q;

endmodule

// File: tb/tb_enemy_car.sv
// tb_enemy_car: scoreboard bench for enemy_car. Every clock the driver
// applies inputs and pushes the expected {car_on,r,g,b,active} seen after
// that edge; the monitor pops and compares one entry per edge.
module tb_enemy_car;

   localparam int SW = 640;
   localparam int SH = 480;
   localparam int CW = 16;
   localparam int CH = 32;
   localparam int BLINK = 60;

   // reference model car phases
   localparam int M_GONE = 0;
   localparam int M_FALL = 1;
   localparam int M_HIT  = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [9:0] pixel_x = '0;
   logic [9:0] pixel_y = '0;
   logic       refresh_tick = 1'b0;
   logic       spawn = 1'b0;
   logic [9:0] spawn_x = '0;
   logic [2:0] speed = '0;
   logic       crash = 1'b0;
   logic       car_on, car_r, car_g, car_b, active;

   enemy_car dut (
      .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .refresh_tick(refresh_tick), .spawn(spawn), .spawn_x(spawn_x),
      .speed(speed), .crash(crash), .car_on(car_on), .car_r(car_r),
      .car_g(car_g), .car_b(car_b), .active(active)
   );

   always #5 clk = ~clk;

   logic [4:0] exp_q[$];
   int n_vec = 0;
   int n_bad = 0;

   // behavioural model of the car
   int m_phase = M_GONE;
   int m_x = 0;
   int m_y = 0;
   int m_frames_left = 0;
   int cur_speed = 0;

   always @(posedge clk) begin
      logic [4:0] exp_v, got_v;
      #1;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         got_v = {car_on, car_r, car_g, car_b, active};
         n_vec++;
         if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL pixel_out t=%0t got on/r/g/b/act=%b required %b (px=%0d py=%0d)",
                     $time, got_v, exp_v, pixel_x, pixel_y);
         end
      end
   end

   function automatic int clip(input int v);
      if (v < 0) return 0;
      if (v > 1023) return 1023;
      return v;
   endfunction

   function automatic int near(input int base, input int span);
      return clip(base + int'($urandom_range(0, span + 8)) - 4);
   endfunction

   task automatic model_clear();
      m_phase = M_GONE;
      m_x = 0;
      m_y = 0;
      m_frames_left = 0;
   endtask

   // Apply inputs for the next edge (caller is at a negedge) and push expectation.
   task automatic step_now(input bit sp, input int sx, input bit tk, input bit cr,
                           input int px, input int py);
      bit on, r, g, b, act;
      spawn = sp; spawn_x = sx[9:0]; refresh_tick = tk; crash = cr;
      pixel_x = px[9:0]; pixel_y = py[9:0]; speed = cur_speed[2:0];
      on = 0; r = 0; g = 0; b = 0;
      if (px >= m_x && px < m_x + CW && py >= m_y && py < m_y + CH) begin
         if (m_phase == M_FALL) begin
            on = 1; r = 1;
            if (py - m_y >= 8 && py - m_y <= 11) begin g = 1; b = 1; end
         end else if (m_phase == M_HIT && ((m_frames_left / 4) % 2 == 1)) begin
            on = 1; r = 1; g = 1;
         end
      end
      if (m_phase == M_GONE) begin
         if (sp) begin
            m_phase = M_FALL; m_x = (sx < SW - CW) ? sx : SW - CW; m_y = 0;
         end
      end else if (m_phase == M_FALL) begin
         if (cr) begin
            m_phase = M_HIT; m_frames_left = BLINK;
         end else if (tk) begin
            if (m_y + cur_speed >= SH) m_phase = M_GONE;
            else m_y = m_y + cur_speed;
         end
      end else begin
         if (tk) begin
            m_frames_left = m_frames_left - 1;
            if (m_frames_left == 0) m_phase = M_GONE;
         end
      end
      act = (m_phase != M_GONE);
      exp_q.push_back({on, r, g, b, act});
   endtask

   task automatic step(input bit sp, input int sx, input bit tk, input bit cr,
                       input int px, input int py);
      @(negedge clk);
      step_now(sp, sx, tk, cr, px, py);
   endtask

   task automatic probe(input int px, input int py);
      step(0, 0, 0, 0, px, py);
   endtask

   task automatic check_zero(input string name);
      n_vec++;
      if ({car_on, car_r, car_g, car_b, active} !== 5'b0) begin
         n_bad++;
         $display("FAIL %s got on/r/g/b/act=%b required 00000", name,
                  {car_on, car_r, car_g, car_b, active});
      end
   endtask

   // Assert reset between edges, check outputs drop at once, release at a negedge.
   task automatic async_reset();
      @(negedge clk);
      spawn = 0; crash = 0; refresh_tick = 0;
      #2 reset = 1'b1;
      #1 check_zero("async_reset");
      @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_zero("reset_state");
      @(negedge clk);
      reset = 1'b0;
      model_clear();

      // spawn at x=100, then pixel (100,0) must be red
      cur_speed = 7;
      step_now(1, 100, 0, 0, 100, 0);
      probe(100, 0);
      probe(99, 0);
      probe(115, 31);
      probe(116, 5);
      probe(100, 32);

      // fall at speed 7: 68 ticks reach y_top=476, tick 69 leaves
      for (int t = 1; t <= 69; t++) begin
         step(0, 0, 1, 0, near(m_x, CW), near(m_y, CH));
         probe(near(m_x, CW), near(m_y, CH));
         if (t == 68) begin
            probe(105, 476);
            probe(105, 475);
            probe(105, 479);
         end
      end
      probe(105, 479);

      // clamp to the right edge and windscreen rows
      cur_speed = 3;
      step(1, 630, 0, 0, 0, 0);
      probe(639, 0);
      probe(623, 0);
      probe(624, 8);
      probe(624, 7);
      probe(630, 11);
      probe(630, 12);
      async_reset();

      // crash together with a tick at y_top=40
      cur_speed = 5;
      step_now(1, 200, 0, 0, 0, 0);
      for (int t = 0; t < 8; t++) step(0, 0, 1, 0, near(m_x, CW), near(m_y, CH));
      step(1, 10, 0, 0, 200, 40);   // spawn while falling is ignored
      probe(199, 40);
      step(0, 0, 1, 1, 201, 40);
      probe(201, 40);
      probe(201, 39);
      probe(201, 71);
      probe(201, 72);
      for (int t = 0; t < BLINK; t++) begin
         step(0, 0, 1, 0, 205, 50);
         step(0, 0, 0, 1, 205, 50);  // crash while crashed is ignored
         step(1, 20, 0, 0, 205, 50); // spawn while crashed is ignored
      end
      probe(205, 50);

      // reset while crashed and visible; spawn on the first edge after release
      cur_speed = 2;
      step(1, 300, 0, 0, 0, 0);
      step(0, 0, 1, 0, 305, 2);
      step(0, 0, 0, 1, 305, 3);
      probe(305, 3);
      async_reset();
      step_now(1, 50, 0, 0, 0, 0);
      probe(50, 0);
      probe(49, 0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         bit sp, tk, cr;
         sp = ($urandom_range(0, 99) < 5);
         tk = ($urandom_range(0, 99) < 25);
         cr = ($urandom_range(0, 99) < 2);
         if (m_phase == M_GONE) cur_speed = $urandom_range(0, 7);
         if ($urandom_range(0, 3) == 0)
            step(sp, $urandom_range(0, 1023), tk, cr, $urandom_range(0, 1023), $urandom_range(0, 1023));
         else
            step(sp, $urandom_range(0, 1023), tk, cr, near(m_x, CW), near(m_y, CH));
      end

      @(negedge clk);
      spawn = 0; crash = 0; refresh_tick = 0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
